// File: rtl/pcihellocore_pushbutton_in.sv
// Avalon-MM push-button input port: synchronize, optionally debounce, capture falling edges, raise irq.
// Define PUSHBUTTON_DEBOUNCE_EN to insert the per-bit debounce counters between synchronizer and state.
module pcihellocore_pushbutton_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] meta, sync, state, state_d, irq_mask, edge_cap, clr_mask;
   logic             wr;

   assign wr = chipselect & ~write_n;

   // Pins idle high, so the synchronizer resets to "released".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '1;
         sync <= '1;
      end else begin
         meta <= in_port;
         sync <= meta;
      end
   end

`ifdef PUSHBUTTON_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      logic [CW-1:0] cnt;
      logic          st;

      // Counter only runs while sync disagrees with the accepted level; any bounce back restarts it.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt <= '0;
            st  <= 1'b1;
         end else if (sync[i] == st) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            st  <= sync[i];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign state[i] = st;
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= '1;
      else       state <= sync;
   end
`endif

   always_comb begin
      clr_mask = '0;
      if (wr && address == 2'd3) clr_mask = writedata[WIDTH-1:0];
   end

   // New falling edges are OR-ed in after the clear, so set wins a same-cycle collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_d  <= '1;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         state_d  <= state;
         edge_cap <= (edge_cap & ~clr_mask) | (state_d & ~state);
         if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = state;
         2'd2:    readdata[WIDTH-1:0] = irq_mask;
         2'd3:    readdata[WIDTH-1:0] = edge_cap;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pcihellocore_pushbutton_in.sv
// Bench for pcihellocore_pushbutton_in: directed literal checks plus randomized pins/bus
// compared every cycle against a behavioural model of the register map.
module tb_pcihellocore_pushbutton_in;

   localparam int W = 4;
   localparam int D = 8;
`ifdef PUSHBUTTON_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif
   // Clock edges from driving a pin to the accepted level changing.
   localparam int ST = DB ? D + 2 : 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata;
   logic          irq;

   int checks = 0;
   int errors = 0;

   pcihellocore_pushbutton_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // Behavioural model: pin samples delayed two edges, then the accepted level follows the
   // sampled level immediately or after D consecutive disagreeing samples.
   logic [W-1:0] m_p1, m_sync, m_st, m_prev_st, m_mask, m_ec, m_fall;
   int           streak [W];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_p1 = '1; m_sync = '1; m_st = '1; m_prev_st = '1; m_mask = '0; m_ec = '0;
         for (int i = 0; i < W; i++) streak[i] = 0;
      end else begin
         m_fall = m_prev_st & ~m_st;
         if (chipselect && !write_n && address == 2'd3) m_ec = m_ec & ~writedata[W-1:0];
         m_ec = m_ec | m_fall;
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
         m_prev_st = m_st;
         if (!DB) begin
            m_st = m_sync;
         end else begin
            for (int i = 0; i < W; i++) begin
               if (m_sync[i] != m_st[i]) streak[i] = streak[i] + 1;
               else                       streak[i] = 0;
               if (streak[i] == D) begin
                  m_st[i]   = m_sync[i];
                  streak[i] = 0;
               end
            end
         end
         m_sync = m_p1;
         m_p1   = in_port;
      end
   end

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_st);
         2'd2:    return 32'(m_mask);
         2'd3:    return 32'(m_ec);
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      checks++;
      if (readdata !== m_read(address)) begin
         errors++;
         $display("FAIL model_rd addr=%0d got=%h exp=%h t=%0t", address, readdata, m_read(address), $time);
      end
      checks++;
      if (irq !== |(m_ec & m_mask)) begin
         errors++;
         $display("FAIL model_irq got=%b exp=%b t=%0t", irq, |(m_ec & m_mask), $time);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      step(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   // Reads a register now, then consumes one cycle.
   task automatic lit(input string name, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      checks++;
      if (readdata !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, readdata, exp);
      end
      step(1);
   endtask

   task automatic lit_irq(input string name, input logic exp);
      checks++;
      if (irq !== exp) begin
         errors++;
         $display("FAIL %s irq got=%b exp=%b", name, irq, exp);
      end
   endtask

   initial begin
      reset = 1'b1; in_port = '1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      step(2);
      reset = 1'b0;
      step(1);
      lit("reset_data", 2'd0, 32'hF);
      lit("reset_rsvd", 2'd1, 32'h0);
      lit("reset_mask", 2'd2, 32'h0);
      lit("reset_ec", 2'd3, 32'h0);
      lit_irq("reset", 1'b0);
      step(100);
      lit("idle_ec", 2'd3, 32'h0);

      // Press bit 0 with mask enabled, then W1C.
      bus_write(2'd2, 32'h1);
      in_port[0] = 1'b0;
      step(ST + 1);
      lit_irq("press0", 1'b1);
      lit("press0_ec", 2'd3, 32'h1);
      bus_write(2'd3, 32'h1);
      lit_irq("w1c0", 1'b0);
      lit("w1c0_ec", 2'd3, 32'h0);
      in_port[0] = 1'b1;
      step(ST + 2);

      // Mask gating on bit 2; rising edge ignored.
      bus_write(2'd2, 32'h0);
      in_port[2] = 1'b0;
      step(ST + 1);
      lit_irq("gated", 1'b0);
      lit("gated_ec", 2'd3, 32'h4);
      bus_write(2'd2, 32'h4);
      lit_irq("unmask", 1'b1);
      in_port[2] = 1'b1;
      step(ST + 2);
      lit("rise_ec", 2'd3, 32'h4);
      lit_irq("rise", 1'b1);
      bus_write(2'd3, 32'h4);
      bus_write(2'd2, 32'h0);

      // Glitch shorter than the debounce window is rejected.
      if (DB) begin
         in_port[1] = 1'b0;
         step(5);
         in_port[1] = 1'b1;
         step(20);
         lit("glitch_data", 2'd0, 32'hF);
         lit("glitch_ec", 2'd3, 32'h0);
      end

      // Clean press on bit 1: state flips exactly ST edges after the pin.
      in_port[1] = 1'b0;
      step(ST - 1);
      lit("hold_before", 2'd0, 32'hF);
      lit("hold_after", 2'd0, 32'hD);
      lit("hold_ec", 2'd3, 32'h2);
      step(10);
      in_port[1] = 1'b1;
      step(ST + 2);
      bus_write(2'd3, 32'h2);

      // W1C lands on the same edge that captures bit 3's fall: set wins.
      in_port[3] = 1'b0;
      step(ST);
      bus_write(2'd3, 32'h8);
      lit("collide_ec", 2'd3, 32'h8);
      in_port[3] = 1'b1;
      step(ST + 2);
      bus_write(2'd3, 32'hF);

      // Bus checks.
      bus_write(2'd0, 32'h0);
      lit("data_ro", 2'd0, 32'hF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      lit("rsvd", 2'd1, 32'h0);
      bus_write(2'd2, 32'hFFFF_FFFF);
      lit("mask_upper", 2'd2, 32'hF);

      // Reset with a capture pending and bit 1 mid-debounce.
      bus_write(2'd2, 32'h1);
      in_port[0] = 1'b0;
      step(ST + 1);
      in_port[1] = 1'b0;
      step(DB ? 5 : 1);
      reset = 1'b1;
      #1;
      lit_irq("rst_mid", 1'b0);
      lit("rst_data", 2'd0, 32'hF);
      lit("rst_ec", 2'd3, 32'h0);
      lit("rst_mask", 2'd2, 32'h0);
      reset = 1'b0;
      in_port = '1;
      step(ST + 3);

      // Random pins and bus traffic, checked by the model every cycle.
      bus_write(2'd2, 32'($urandom_range(0, 15)));
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            bus_write(2'($urandom_range(2, 3)), $urandom);
         end
         step($urandom_range(1, DB ? 12 : 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcihellocore_pushbutton_in.md
# pcihellocore_pushbutton_in

Avalon-MM slave input port that samples up to 32 active-low board inputs (push-buttons), synchronizes and optionally debounces them, latches falling edges into a per-bit capture register, and raises a level interrupt. It sits on the PCIe-to-Avalon bridge fabric next to the LED output ports. It gives the host driver the read direction: a readable pin state plus an interrupt-driven event register.

## Interface
- WIDTH, 4: number of input pins, legal 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level. Legal ≥ 2. Used only with the debounce feature.
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  word address of register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous pins, active-low (0 = pressed).
- readdata  output  32  read data, zero-extended above WIDTH.
- irq  output  1  level interrupt request.

## Operation
- Register map, 32-bit words:
  - addr 0 DATA: read-only, debounced pin state; writes ignored.
  - addr 1: reserved; reads 0, writes ignored.
  - addr 2 IRQMASK: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - addr 3 EDGECAPTURE: read, write-1-to-clear per bit.
- Write accepted when chipselect=1 and write_n=0.
- Reads are combinational from address with zero wait states and read latency 0. readdata is valid whenever address is stable; chipselect is not required.
- Input path: a 2-flop synchronizer per bit produces sync, then the debounce stage (see Configuration) produces state. DATA returns state.
- Edge detect: state_d is state delayed 1 cycle. A falling edge on bit i is state_d[i]=1 & state[i]=0. It sets EDGECAPTURE[i]. Rising edges are ignored.
- Clear/set collision: a W1C write and a new edge on the same bit in the same cycle leave the bit set (set wins). Bits written 0 are unchanged.
- irq = |(EDGECAPTURE & IRQMASK), registered-free combinational OR of flops.
- Reset values:
  - synchronizer flops, state, and state_d: all 1 (released), so no edge is captured after reset.
  - IRQMASK = 0, EDGECAPTURE = 0, debounce counters = 0.
  - irq = 0; readdata = 0 except DATA, which reads all-ones in [WIDTH-1:0].
- Reset mid-debounce abandons the pending level; the counter returns to 0.

## Timing
- Pin change to sync: 2 cycles (3 including input sampling uncertainty).
- Without debounce: sync to state in 1 cycle. EDGECAPTURE is set the cycle after state falls. irq asserts in the same cycle as EDGECAPTURE.
- With debounce: state updates on the cycle the bit's counter reaches DEBOUNCE_CYCLES-1 while sync≠state. Total pin-to-state latency is DEBOUNCE_CYCLES+2 cycles for a clean step.
- W1C write at edge N: the bit reads 0 from edge N+1, and irq deasserts at edge N+1 if no other masked bit is set.
- IRQMASK write takes effect on irq the cycle after the write edge.

## Configuration
- PUSHBUTTON_DEBOUNCE_EN defined:
  - per-bit counter of width $clog2(DEBOUNCE_CYCLES).
  - While sync[i]==state[i], the counter is held at 0.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1, state[i] takes sync[i] and the counter clears.
  - Any bounce back to the state level before then resets the counter.
- Undefined: no counters; state is sync registered one cycle, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset release with in_port=4'hF:
  - DATA reads 0x0000000F; IRQMASK and EDGECAPTURE read 0; irq=0.
  - No edge is captured for 100 cycles.
- Debounce off, IRQMASK=0x1, drive in_port[0] 1→0:
  - EDGECAPTURE reads 0x1 by cycle 4, and irq=1.
  - Write 0x1 to addr 3: EDGECAPTURE=0 and irq=0 the next cycle.
- Mask gating, IRQMASK=0x0, press bit 2:
  - EDGECAPTURE=0x4 and irq=0.
  - Write IRQMASK=0x4: irq=1 one cycle later.
  - Release bit 2 (rising edge): no change.
- Debounce on, DEBOUNCE_CYCLES=8, bit 1:
  - Glitch 0 for 5 cycles then back to 1: DATA stays 0xF and EDGECAPTURE stays 0.
  - Hold 0 for 20 cycles: DATA becomes 0xD after 10 cycles, and EDGECAPTURE=0x2.
- Collision: arrange W1C write of 0x8 to land in the same cycle bit 3's falling edge is detected. EDGECAPTURE[3] reads 1 afterwards.
- Bus checks:
  - addr 1 reads 0.
  - A write to addr 0 leaves DATA unchanged.
  - Asserting reset while a debounce count is pending returns DATA to 0xF and clears EDGECAPTURE.
